freq_meter: RTL and testbench

FREQ_METER -- requirements
Module: freq_meter

---
 rtl/freq_meter.sv | 249 ++++++++++++++++++++++++
 tb/tb_freq_meter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// Frequency meter: counts rising edges of an asynchronous input over a fixed
// gate period and shows the result on a multiplexed 7-segment display.
// Optional build macro FREQ_METER_BLANK_EN blanks leading-zero digits.
module freq_meter #(
    parameter int unsigned GATE_CYCLES    = 100000000,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned REFRESH_CYCLES = 100000
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              IN,
    output logic [CNT_W-1:0]  FREQ,
    output logic              FREQ_VALID,
    output logic              OVERFLOW,
    output logic [6:0]        CATHODE,
    output logic [DIGITS-1:0] ANODE,
    output logic              DP
);

    localparam int unsigned GATE_W = $clog2(GATE_CYCLES);
    localparam int unsigned REF_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int unsigned DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned STEP_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;
    localparam int unsigned BCD_W  = 4 * DIGITS;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [63:0]      DEC_LIM = 64'(10) ** DIGITS;

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_LOAD
    } state_t;

    // Active-low segment patterns g..a for BCD digits.
    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    logic              sync1_q, sync2_q, hist_q;
    logic [GATE_W-1:0] gate_cnt_q;
    logic [CNT_W-1:0]  edge_cnt_q;
    logic [CNT_W-1:0]  freq_q;
    logic              freq_valid_q;
    logic              ovf_q;

    logic              edge_c;
    logic              gate_term_c;
    logic [CNT_W-1:0]  cnt_tot_c;
    logic              ovf_c;

    state_t            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [CNT_W-1:0]  bin_q, bin_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d, bcd_adj_c;
    logic              cvt_ovf_q, cvt_ovf_d;
    logic [BCD_W-1:0]  disp_q, disp_d;
    logic              disp_ovf_q, disp_ovf_d;

    logic [REF_W-1:0]  ref_cnt_q, ref_cnt_d;
    logic              ref_term_c;
    logic [DIG_W-1:0]  digit_q, digit_d;
    logic [3:0]        nib_c;
    logic [6:0]        seg_c;
    logic [6:0]        cathode_q;
    logic [DIGITS-1:0] anode_q;
`ifdef FREQ_METER_BLANK_EN
    logic              upper_zero_c;
`endif

    // Edge detect, gate terminal and saturating count including this cycle's edge.
    always_comb begin
        edge_c      = sync2_q & ~hist_q;
        gate_term_c = (gate_cnt_q == GATE_W'(GATE_CYCLES - 1));
        cnt_tot_c   = (edge_c && (edge_cnt_q != CNT_MAX)) ? edge_cnt_q + CNT_W'(1) : edge_cnt_q;
        ovf_c       = (cnt_tot_c == CNT_MAX) || (64'(cnt_tot_c) >= DEC_LIM);
    end

    // Synchronizer, gate timer, edge counter and result latch.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            hist_q       <= 1'b0;
            gate_cnt_q   <= '0;
            edge_cnt_q   <= '0;
            freq_q       <= '0;
            freq_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            sync1_q      <= IN;
            sync2_q      <= sync1_q;
            hist_q       <= sync2_q;
            freq_valid_q <= gate_term_c;
            if (gate_term_c) begin
                gate_cnt_q <= '0;
                edge_cnt_q <= '0;
                freq_q     <= cnt_tot_c;
                ovf_q      <= ovf_c;
            end else begin
                gate_cnt_q <= gate_cnt_q + GATE_W'(1);
                edge_cnt_q <= cnt_tot_c;
            end
        end
    end

    // Conversion FSM next state: latch result, shift-add-3 per bit, then publish.
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cvt_ovf_d  = cvt_ovf_q;
        disp_d     = disp_q;
        disp_ovf_d = disp_ovf_q;
        bcd_adj_c  = dd_adjust(bcd_q);
        case (state_q)
            S_IDLE: begin
                if (freq_valid_q) begin
                    state_d   = S_CONVERT;
                    step_d    = '0;
                    bin_d     = freq_q;
                    bcd_d     = '0;
                    cvt_ovf_d = ovf_q;
                end
            end
            S_CONVERT: begin
                bcd_d  = {bcd_adj_c[BCD_W-2:0], bin_q[CNT_W-1]};
                bin_d  = bin_q << 1;
                step_d = step_q + STEP_W'(1);
                if (step_q == STEP_W'(CNT_W - 1)) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                disp_d     = bcd_q;
                disp_ovf_d = cvt_ovf_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Conversion FSM state and datapath registers.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q    <= S_IDLE;
            step_q     <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            cvt_ovf_q  <= 1'b0;
            disp_q     <= '0;
            disp_ovf_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cvt_ovf_q  <= cvt_ovf_d;
            disp_q     <= disp_d;
            disp_ovf_q <= disp_ovf_d;
        end
    end

    // Digit scan and segment selection for the digit active next cycle.
    always_comb begin
        ref_term_c = (ref_cnt_q == REF_W'(REFRESH_CYCLES - 1));
        ref_cnt_d  = ref_term_c ? '0 : ref_cnt_q + REF_W'(1);
        digit_d    = digit_q;
        if (ref_term_c) begin
            digit_d = (digit_q == DIG_W'(DIGITS - 1)) ? '0 : digit_q + DIG_W'(1);
        end
        nib_c = 4'd0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (digit_d == DIG_W'(i)) begin
                nib_c = disp_d[4*i +: 4];
            end
        end
        seg_c = seg7(nib_c);
`ifdef FREQ_METER_BLANK_EN
        upper_zero_c = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if ((DIG_W'(i) >= digit_d) && (disp_d[4*i +: 4] != 4'd0)) begin
                upper_zero_c = 1'b0;
            end
        end
        if (upper_zero_c && (digit_d != '0)) begin
            seg_c = SEG_BLANK;
        end
`endif
        if (disp_ovf_d) begin
            seg_c = SEG_DASH;
        end
    end

    // Refresh counter and registered display drivers.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            ref_cnt_q <= '0;
            digit_q   <= '0;
            anode_q   <= ~DIGITS'(1);
            cathode_q <= SEG_ZERO;
        end else begin
            ref_cnt_q <= ref_cnt_d;
            digit_q   <= digit_d;
            anode_q   <= ~(DIGITS'(1) << digit_d);
            cathode_q <= seg_c;
        end
    end

    assign FREQ       = freq_q;
    assign FREQ_VALID = freq_valid_q;
    assign OVERFLOW   = ovf_q;
    assign CATHODE    = cathode_q;
    assign ANODE      = anode_q;
    assign DP         = 1'b1;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (CNT_W=8 and CNT_W=5) share stimulus;
// expected values come from an edge-counting model over the logged input.
module tb_freq_meter;

    localparam int GATE = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_sig = 1'b0;

    logic [7:0] freq;
    logic       fv, ovf, dp;
    logic [6:0] cath;
    logic [3:0] an;
    logic [4:0] freq_s;
    logic       fv_s, ovf_s, dp_s;
    logic [6:0] cath_s;
    logic [3:0] an_s;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    int vcnt   = 0;
    bit in_log[$];

    always #5 clk = ~clk;

    freq_meter #(.GATE_CYCLES(100), .CNT_W(8), .DIGITS(4), .REFRESH_CYCLES(4)) dut (
        .CLK(clk), .RESET_N(rst_n), .IN(in_sig), .FREQ(freq), .FREQ_VALID(fv),
        .OVERFLOW(ovf), .CATHODE(cath), .ANODE(an), .DP(dp)
    );

    freq_meter #(.GATE_CYCLES(100), .CNT_W(5), .DIGITS(4), .REFRESH_CYCLES(4)) dut_s (
        .CLK(clk), .RESET_N(rst_n), .IN(in_sig), .FREQ(freq_s), .FREQ_VALID(fv_s),
        .OVERFLOW(ovf_s), .CATHODE(cath_s), .ANODE(an_s), .DP(dp_s)
    );

    // Edges counted in gate g: a rise between samples j-3 and j-2 is credited
    // to cycle j; samples before release read as 0.
    function automatic int unsigned exp_freq(int g, int w);
        int unsigned n = 0;
        int unsigned lim = (32'd1 << w) - 1;
        bit a, b;
        for (int j = GATE * g; j < GATE * g + GATE; j++) begin
            a = (j >= 2) ? in_log[j-2] : 1'b0;
            b = (j >= 3) ? in_log[j-3] : 1'b0;
            if (a && !b) n++;
        end
        return (n > lim) ? lim : n;
    endfunction

    function automatic bit exp_ovf(int unsigned f, int w);
        return (f == (32'd1 << w) - 1) || (f >= 10000);
    endfunction

    function automatic logic [6:0] exp_seg(int unsigned f, bit ov, int d);
        int unsigned p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        if (ov) return 7'b0111111;
`ifdef FREQ_METER_BLANK_EN
        if (d > 0 && f < p) return 7'b1111111;
`endif
        case ((f / p) % 10)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    // Input pattern for sample k under each stimulus mode.
    function automatic bit stim(int mode, int k);
        int ph;
        ph = k % GATE;
        case (mode)
            0: return bit'((k / 2) % 2);
            1: return bit'(k % 2);
            2: return bit'($urandom_range(0, 1));
            3: return k >= 97;
            4: return (ph >= 15) && (ph < 80) && ((ph % 10) >= 5);
            6: return k >= 98;
            default: return 1'b0;
        endcase
    endfunction

    task automatic tick(input bit v);
        in_sig = v;
        @(posedge clk);
        in_log.push_back(v);
        #1;
        cyc++;
        if (fv) vcnt++;
    endtask

    task automatic drive(input int mode, input int n);
        repeat (n) tick(stim(mode, cyc));
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        in_log.delete();
        cyc  = 0;
        vcnt = 0;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        in_sig = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if ({freq, fv, ovf, cath, an, dp} !== {8'd0, 1'b0, 1'b0, 7'b1000000, 4'b1110, 1'b1})
            $display("FAIL reset_state got %h want %h", {freq, fv, ovf, cath, an, dp},
                     {8'd0, 1'b0, 1'b0, 7'b1000000, 4'b1110, 1'b1});
        else passes++;
        checks++;
        if ({freq_s, fv_s, ovf_s, cath_s, an_s, dp_s} !== {5'd0, 1'b0, 1'b0, 7'b1000000, 4'b1110, 1'b1})
            $display("FAIL reset_state_s got %h want %h", {freq_s, fv_s, ovf_s, cath_s, an_s, dp_s},
                     {5'd0, 1'b0, 1'b0, 7'b1000000, 4'b1110, 1'b1});
        else passes++;
        rst_n = 1'b1;
        in_log.delete();
        cyc  = 0;
        vcnt = 0;
    endtask

    // Per gate: valid pulse timing and count, FREQ/OVERFLOW, then one full scan of the display.
    task automatic test_stream(input string name, input int mode, input int ngates);
        int unsigned ef, es;
        int idx;
        logic [3:0] ea;
        do_reset(2);
        for (int g = 0; g < ngates; g++) begin
            drive(mode, GATE * g + GATE - 1 - cyc);
            checks++;
            if (vcnt !== g || fv !== 1'b0)
                $display("FAIL %s_valid_early g=%0d got pulses=%0d fv=%b want %0d 0", name, g, vcnt, fv, g);
            else passes++;
            drive(mode, 1);
            checks++;
            if (fv !== 1'b1 || fv_s !== 1'b1 || vcnt !== g + 1)
                $display("FAIL %s_valid g=%0d got fv=%b fv_s=%b pulses=%0d want 1 1 %0d", name, g, fv, fv_s, vcnt, g + 1);
            else passes++;
            ef = exp_freq(g, 8);
            es = exp_freq(g, 5);
            checks++;
            if ({freq, ovf} !== {8'(ef), exp_ovf(ef, 8)})
                $display("FAIL %s_freq g=%0d got %0d ovf=%b want %0d ovf=%b", name, g, freq, ovf, ef, exp_ovf(ef, 8));
            else passes++;
            checks++;
            if ({freq_s, ovf_s} !== {5'(es), exp_ovf(es, 5)})
                $display("FAIL %s_freq_s g=%0d got %0d ovf=%b want %0d ovf=%b", name, g, freq_s, ovf_s, es, exp_ovf(es, 5));
            else passes++;
            drive(mode, 20);
            repeat (16) begin
                drive(mode, 1);
                idx = (cyc / 4) % 4;
                ea  = ~(4'b0001 << idx);
                checks++;
                if (an !== ea || an_s !== ea || dp !== 1'b1 || dp_s !== 1'b1)
                    $display("FAIL %s_anode cyc=%0d got %b %b dp=%b%b want %b dp=11", name, cyc, an, an_s, dp, dp_s, ea);
                else passes++;
                checks++;
                if (cath !== exp_seg(ef, exp_ovf(ef, 8), idx))
                    $display("FAIL %s_cathode cyc=%0d digit=%0d got %b want %b", name, cyc, idx, cath,
                             exp_seg(ef, exp_ovf(ef, 8), idx));
                else passes++;
                checks++;
                if (cath_s !== exp_seg(es, exp_ovf(es, 5), idx))
                    $display("FAIL %s_cathode_s cyc=%0d digit=%0d got %b want %b", name, cyc, idx, cath_s,
                             exp_seg(es, exp_ovf(es, 5), idx));
                else passes++;
            end
        end
    endtask

    task automatic test_toggle2();
        test_stream("toggle2", 0, 3);
        checks++;
        if ({freq, ovf, freq_s, ovf_s} !== {8'd25, 1'b0, 5'd25, 1'b0})
            $display("FAIL toggle2_steady got %0d/%b %0d/%b want 25/0 25/0", freq, ovf, freq_s, ovf_s);
        else passes++;
    endtask

    task automatic test_saturate();
        test_stream("toggle1", 1, 3);
        checks++;
        if ({freq, ovf, freq_s, ovf_s} !== {8'd50, 1'b0, 5'd31, 1'b1})
            $display("FAIL saturate got %0d/%b %0d/%b want 50/0 31/1", freq, ovf, freq_s, ovf_s);
        else passes++;
        checks++;
        if (cath_s !== 7'b0111111)
            $display("FAIL saturate_dash got %b want 0111111", cath_s);
        else passes++;
    endtask

    task automatic test_terminal();
        do_reset(2);
        drive(3, 100);
        checks++;
        if (freq !== 8'd1 || fv !== 1'b1) $display("FAIL terminal_g0 got %0d fv=%b want 1 1", freq, fv);
        else passes++;
        drive(3, 100);
        checks++;
        if (freq !== 8'd0 || fv !== 1'b1) $display("FAIL terminal_g1 got %0d fv=%b want 0 1", freq, fv);
        else passes++;
        do_reset(2);
        drive(6, 100);
        checks++;
        if (freq !== 8'd0) $display("FAIL late_edge_g0 got %0d want 0", freq);
        else passes++;
        drive(6, 100);
        checks++;
        if (freq !== 8'd1) $display("FAIL late_edge_g1 got %0d want 1", freq);
        else passes++;
    endtask

    task automatic test_mid_reset();
        do_reset(2);
        drive(1, 50);
        do_reset(1);
        checks++;
        if ({freq, fv, ovf, cath, an, dp, freq_s, ovf_s} !==
            {8'd0, 1'b0, 1'b0, 7'b1000000, 4'b1110, 1'b1, 5'd0, 1'b0})
            $display("FAIL mid_reset_state got %h want %h", {freq, fv, ovf, cath, an, dp, freq_s, ovf_s},
                     {8'd0, 1'b0, 1'b0, 7'b1000000, 4'b1110, 1'b1, 5'd0, 1'b0});
        else passes++;
        drive(1, 99);
        checks++;
        if (vcnt !== 0 || fv !== 1'b0) $display("FAIL mid_reset_early got pulses=%0d fv=%b want 0 0", vcnt, fv);
        else passes++;
        drive(1, 1);
        checks++;
        if (fv !== 1'b1 || freq !== 8'(exp_freq(0, 8)))
            $display("FAIL mid_reset_gate got fv=%b freq=%0d want 1 %0d", fv, freq, exp_freq(0, 8));
        else passes++;
    endtask

    task automatic test_digit7();
        int idx;
        logic [6:0] es;
        test_stream("digit7", 4, 2);
        checks++;
        if (freq !== 8'd7) $display("FAIL digit7_freq got %0d want 7", freq);
        else passes++;
        repeat (16) begin
            drive(4, 1);
            idx = (cyc / 4) % 4;
`ifdef FREQ_METER_BLANK_EN
            es = (idx == 0) ? 7'b1111000 : 7'b1111111;
`else
            es = (idx == 0) ? 7'b1111000 : 7'b1000000;
`endif
            checks++;
            if (cath !== es || an !== ~(4'b0001 << idx))
                $display("FAIL digit7_display cyc=%0d got %b/%b want %b/%b", cyc, cath, an, es, ~(4'b0001 << idx));
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_toggle2();
        test_saturate();
        test_terminal();
        test_mid_reset();
        test_digit7();
        test_stream("random", 2, 4);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
